// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the data-memory arbiter and dmemory.
// Port 0 is the core load/store unit; port 1 is the program loader/debug port.
// The slave modport is the arbiter's view; the master modport is the
// requesters' and memory's view.
interface dmem_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_addr0;
  logic [31:0] req_addr1;
  logic        req_write0;
  logic        req_write1;
  logic [1:0]  req_size0;
  logic [1:0]  req_size1;
  logic [31:0] req_wdata0;
  logic [31:0] req_wdata1;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_address;
  logic        mem_read_write;
  logic [1:0]  mem_access_size;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;

  modport slave (
    input  req_valid, req_addr0, req_addr1, req_write0, req_write1,
           req_size0, req_size1, req_wdata0, req_wdata1, rsp_ready, mem_data_out,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_address, mem_read_write, mem_access_size, mem_data_in
  );

  modport master (
    output req_valid, req_addr0, req_addr1, req_write0, req_write1,
           req_size0, req_size1, req_wdata0, req_wdata1, rsp_ready, mem_data_out,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_address, mem_read_write, mem_access_size, mem_data_in
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between two
// requesters. One transaction at a time: IDLE (grant) -> ACCESS (one memory
// cycle) -> RESP (hold response until the owning port takes it).
// Requests that are misaligned, of illegal size or outside the memory window
// still pass through ACCESS but never write and return zero data with rsp_err.
module dmem_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h0100_0000,
  parameter logic [32:0] MEM_BYTES = 33'd1048576
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Last valid byte address, kept in 33 bits so the range test cannot wrap.
  localparam logic [32:0] LAST_ADDR = {1'b0, BASE_ADDR} + MEM_BYTES - 33'd1;

  // Flags size, alignment and range errors for one request.
  function automatic logic req_error(input logic [31:0] addr, input logic [1:0] size);
    logic [32:0] end_addr;
    end_addr  = {1'b0, addr} + (33'd1 << size) - 33'd1;
    req_error = (size == 2'd3)
              | ((size == 2'd1) & addr[0])
              | ((size == 2'd2) & (addr[1:0] != 2'd0))
              | ({1'b0, addr} < {1'b0, BASE_ADDR})
              | (end_addr > LAST_ADDR);
  endfunction

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        port_q, port_d;
  logic        write_q, write_d;
  logic        err_q, err_d;
  logic [1:0]  rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic        mem_rw_q, mem_rw_d;
  logic [1:0]  mem_size_q, mem_size_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic [1:0]  grant_s;
  logic        sel_s;
  logic [31:0] sel_addr_s;
  logic        sel_write_s;
  logic [1:0]  sel_size_s;
  logic [31:0] sel_wdata_s;
  logic        sel_err_s;

  // Pick the winning port in IDLE: sole requester, or the one not granted last.
  always_comb begin
    grant_s = 2'b00;
    sel_s   = 1'b0;
    if ((state_q == ST_IDLE) && !reset) begin
      case (bus.req_valid)
        2'b01: begin grant_s = 2'b01; sel_s = 1'b0; end
        2'b10: begin grant_s = 2'b10; sel_s = 1'b1; end
        2'b11: begin
          if (last_grant_q) begin
            grant_s = 2'b01;
            sel_s   = 1'b0;
          end else begin
            grant_s = 2'b10;
            sel_s   = 1'b1;
          end
        end
        default: begin grant_s = 2'b00; sel_s = 1'b0; end
      endcase
    end else begin
      grant_s = 2'b00;
      sel_s   = 1'b0;
    end
  end

  // Route the winning port's request fields and classify it.
  always_comb begin
    if (sel_s) begin
      sel_addr_s  = bus.req_addr1;
      sel_write_s = bus.req_write1;
      sel_size_s  = bus.req_size1;
      sel_wdata_s = bus.req_wdata1;
    end else begin
      sel_addr_s  = bus.req_addr0;
      sel_write_s = bus.req_write0;
      sel_size_s  = bus.req_size0;
      sel_wdata_s = bus.req_wdata0;
    end
    sel_err_s = req_error(sel_addr_s, sel_size_s);
  end

  // Next-state logic for the IDLE -> ACCESS -> RESP sequence and its outputs.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    port_d        = port_q;
    write_d       = write_q;
    err_d         = err_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    mem_address_d = mem_address_q;
    mem_size_d    = mem_size_q;
    mem_wdata_d   = mem_wdata_q;
    mem_rw_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_s != 2'b00) begin
          state_d       = ST_ACCESS;
          port_d        = sel_s;
          last_grant_d  = sel_s;
          write_d       = sel_write_s;
          err_d         = sel_err_s;
          mem_address_d = sel_addr_s;
          mem_size_d    = sel_size_s;
          mem_wdata_d   = sel_wdata_s;
          mem_rw_d      = sel_write_s & ~sel_err_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        state_d     = ST_RESP;
        rsp_err_d   = err_q;
        rsp_rdata_d = (!write_q && !err_q) ? bus.mem_data_out : 32'd0;
        rsp_valid_d = port_q ? 2'b10 : 2'b01;
      end
      ST_RESP: begin
        if (bus.rsp_ready[port_q]) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 2'b00;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 2'b00;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= 1'b1;
      port_q        <= 1'b0;
      write_q       <= 1'b0;
      err_q         <= 1'b0;
      rsp_valid_q   <= 2'b00;
      rsp_rdata_q   <= 32'd0;
      rsp_err_q     <= 1'b0;
      mem_address_q <= 32'd0;
      mem_rw_q      <= 1'b0;
      mem_size_q    <= 2'd0;
      mem_wdata_q   <= 32'd0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      port_q        <= port_d;
      write_q       <= write_d;
      err_q         <= err_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      mem_address_q <= mem_address_d;
      mem_rw_q      <= mem_rw_d;
      mem_size_q    <= mem_size_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign bus.req_ready       = grant_s;
  assign bus.rsp_valid       = rsp_valid_q;
  assign bus.rsp_rdata       = rsp_rdata_q;
  assign bus.rsp_err         = rsp_err_q;
  assign bus.mem_address     = mem_address_q;
  assign bus.mem_read_write  = mem_rw_q;
  assign bus.mem_access_size = mem_size_q;
  assign bus.mem_data_in     = mem_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a table of single transactions plus
// hand-written sequences for reset abort, round-robin and response stall.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  int unsigned write_count = 0;

  dmem_arbiter_if bus ();

  dmem_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Small memory model: 16 words aliased on address bits [5:2]; a write stores
  // the whole bus word, which is enough since the arbiter passes data through.
  logic [31:0] mem_arr [0:15];

  always_comb bus.mem_data_out = mem_arr[bus.mem_address[5:2]];

  always @(posedge clk) begin
    if (bus.mem_read_write) begin
      mem_arr[bus.mem_address[5:2]] <= bus.mem_data_in;
      write_count <= write_count + 1;
    end
  end

  typedef struct {
    logic        port;
    logic [31:0] addr;
    logic        write;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input logic p, input logic [31:0] a, input logic w,
                         input logic [1:0] s, input logic [31:0] d);
    if (p) begin
      bus.req_addr1 = a; bus.req_write1 = w; bus.req_size1 = s; bus.req_wdata1 = d;
      bus.req_valid[1] = 1'b1;
    end else begin
      bus.req_addr0 = a; bus.req_write0 = w; bus.req_size0 = s; bus.req_wdata0 = d;
      bus.req_valid[0] = 1'b1;
    end
  endtask

  // Returns #1 after the negedge on which some port is ready, or after the budget.
  task automatic wait_ready();
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus.req_ready != 2'b00) break;
      @(negedge clk);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'd0);
    check({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
    check({tag, "_mem_rw"}, 32'(bus.mem_read_write), 32'd0);
    check({tag, "_mem_addr"}, bus.mem_address, 32'd0);
    check({tag, "_mem_size"}, 32'(bus.mem_access_size), 32'd0);
    check({tag, "_mem_din"}, bus.mem_data_in, 32'd0);
  endtask

  task automatic run_txn(input vec_t v);
    logic [1:0]  exp_v;
    logic        exp_wr;
    int unsigned wc0;
    exp_v  = v.port ? 2'b10 : 2'b01;
    exp_wr = v.write & ~v.exp_err;
    @(negedge clk);
    set_req(v.port, v.addr, v.write, v.size, v.wdata);
    wait_ready();
    check("txn_req_ready", 32'(bus.req_ready), 32'(exp_v));
    wc0 = write_count;
    @(negedge clk);
    bus.req_valid = 2'b00;
    check("txn_access_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("txn_access_mem_rw", 32'(bus.mem_read_write), 32'(exp_wr));
    check("txn_access_mem_addr", bus.mem_address, v.addr);
    if (v.write) check("txn_access_mem_din", bus.mem_data_in, v.wdata);
    @(negedge clk);
    check("txn_rsp_valid", 32'(bus.rsp_valid), 32'(exp_v));
    check("txn_rsp_err", 32'(bus.rsp_err), 32'(v.exp_err));
    check("txn_rsp_rdata", bus.rsp_rdata, v.exp_rdata);
    check("txn_write_count", write_count - wc0, 32'(exp_wr));
    bus.rsp_ready[v.port] = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 2'b00;
    check("txn_rsp_done", 32'(bus.rsp_valid), 32'd0);
  endtask

  // Both ports request continuously; grants must alternate starting at 'first'.
  task automatic arb_sequence(input int n, input logic first);
    logic [1:0] exp_g;
    for (int k = 0; k < n; k++) begin
      exp_g = ((first ^ k[0]) == 1'b1) ? 2'b10 : 2'b01;
      wait_ready();
      check("arb_grant", 32'(bus.req_ready), 32'(exp_g));
      @(negedge clk);
      @(negedge clk);
      check("arb_rsp_valid", 32'(bus.rsp_valid), 32'(exp_g));
      check("arb_rsp_err", 32'(bus.rsp_err), 32'd0);
      bus.rsp_ready = 2'b11;
      @(negedge clk);
      bus.rsp_ready = 2'b00;
      if (k == n - 1) bus.req_valid = 2'b00;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, 32'h0100_0000, 1'b1, 2'd2, 32'h0000_55D4, 1'b0, 32'h0000_0000};
    vecs[1]  = '{1'b0, 32'h0100_0000, 1'b0, 2'd2, 32'h0000_0000, 1'b0, 32'h0000_55D4};
    vecs[2]  = '{1'b1, 32'h0100_0001, 1'b1, 2'd1, 32'h0000_BEEF, 1'b1, 32'h0000_0000};
    vecs[3]  = '{1'b1, 32'h00FF_FFFC, 1'b0, 2'd2, 32'h0000_0000, 1'b1, 32'h0000_0000};
    vecs[4]  = '{1'b0, 32'h010F_FFFC, 1'b1, 2'd2, 32'hCAFE_F00D, 1'b0, 32'h0000_0000};
    vecs[5]  = '{1'b0, 32'h010F_FFFC, 1'b0, 2'd2, 32'h0000_0000, 1'b0, 32'hCAFE_F00D};
    vecs[6]  = '{1'b1, 32'h010F_FFFE, 1'b0, 2'd1, 32'h0000_0000, 1'b0, 32'hCAFE_F00D};
    vecs[7]  = '{1'b0, 32'h010F_FFFE, 1'b0, 2'd2, 32'h0000_0000, 1'b1, 32'h0000_0000};
    vecs[8]  = '{1'b1, 32'h0100_0000, 1'b0, 2'd3, 32'h0000_0000, 1'b1, 32'h0000_0000};
    vecs[9]  = '{1'b0, 32'h0110_0000, 1'b0, 2'd0, 32'h0000_0000, 1'b1, 32'h0000_0000};
    vecs[10] = '{1'b1, 32'hFFFF_FFFF, 1'b0, 2'd0, 32'h0000_0000, 1'b1, 32'h0000_0000};
    vecs[11] = '{1'b1, 32'h010F_FFFF, 1'b1, 2'd0, 32'h0000_00A5, 1'b0, 32'h0000_0000};
    vecs[12] = '{1'b0, 32'h010F_FFFF, 1'b0, 2'd0, 32'h0000_0000, 1'b0, 32'h0000_00A5};
    vecs[13] = '{1'b0, 32'h0100_0002, 1'b0, 2'd1, 32'h0000_0000, 1'b0, 32'h0000_55D4};

    bus.req_valid = 2'b00; bus.rsp_ready = 2'b00;
    bus.req_addr0 = 32'd0; bus.req_write0 = 1'b0; bus.req_size0 = 2'd0; bus.req_wdata0 = 32'd0;
    bus.req_addr1 = 32'd0; bus.req_write1 = 1'b0; bus.req_size1 = 2'd0; bus.req_wdata1 = 32'd0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b0;

    // Reset during RESP of a port-0 load, with port 1 waiting.
    @(negedge clk);
    set_req(1'b0, 32'h0100_0000, 1'b0, 2'd2, 32'd0);
    wait_ready();
    check("rst_resp_grant", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = 2'b00;
    @(negedge clk);
    check("rst_resp_valid_before", 32'(bus.rsp_valid), 32'd1);
    set_req(1'b1, 32'h010F_FFFC, 1'b0, 2'd2, 32'd0);
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_resp_now");
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("rst_resp_held");
    set_req(1'b0, 32'h0100_0000, 1'b0, 2'd2, 32'd0);
    reset = 1'b0;
    arb_sequence(4, 1'b0);

    // Reset during ACCESS of a store must suppress the write.
    begin
      int unsigned wc0;
      @(negedge clk);
      set_req(1'b0, 32'h0100_0010, 1'b1, 2'd2, 32'h1234_5678);
      wait_ready();
      check("rst_acc_grant", 32'(bus.req_ready), 32'd1);
      wc0 = write_count;
      @(negedge clk);
      bus.req_valid = 2'b00;
      check("rst_acc_mem_rw_before", 32'(bus.mem_read_write), 32'd1);
      reset = 1'b1;
      #1;
      check("rst_acc_mem_rw_after", 32'(bus.mem_read_write), 32'd0);
      @(negedge clk);
      @(negedge clk);
      check("rst_acc_no_write", write_count - wc0, 32'd0);
      check("rst_acc_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      reset = 1'b0;
    end

    for (int i = 0; i < 14; i++) run_txn(vecs[i]);

    // Response stall: port 0 withholds rsp_ready, port 1 raises its own and waits.
    begin
      logic [31:0] held;
      @(negedge clk);
      set_req(1'b0, 32'h010F_FFFC, 1'b0, 2'd2, 32'd0);
      wait_ready();
      check("stall_grant", 32'(bus.req_ready), 32'd1);
      @(negedge clk);
      bus.req_valid = 2'b00;
      set_req(1'b1, 32'h0100_0000, 1'b0, 2'd2, 32'd0);
      bus.rsp_ready = 2'b10;
      @(negedge clk);
      check("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("stall_rsp_rdata", bus.rsp_rdata, 32'h0000_00A5);
      held = bus.rsp_rdata;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        check("stall_hold_valid", 32'(bus.rsp_valid), 32'd1);
        check("stall_hold_rdata", bus.rsp_rdata, held);
        check("stall_hold_req_ready", 32'(bus.req_ready), 32'd0);
      end
      bus.rsp_ready = 2'b01;
      @(negedge clk);
      bus.rsp_ready = 2'b00;
      #1;
      check("stall_released_valid", 32'(bus.rsp_valid), 32'd0);
      check("stall_next_grant", 32'(bus.req_ready), 32'd2);
      @(negedge clk);
      bus.req_valid = 2'b00;
      @(negedge clk);
      check("stall_p1_rsp_valid", 32'(bus.rsp_valid), 32'd2);
      check("stall_p1_rsp_rdata", bus.rsp_rdata, 32'h0000_55D4);
      bus.rsp_ready = 2'b10;
      @(negedge clk);
      bus.rsp_ready = 2'b00;
      check("stall_p1_done", 32'(bus.rsp_valid), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
